// File: rtl/layer_compositor_pkg.sv
// Shared types and constants for the layer compositor: segment entry layout and colour widths.
package layer_compositor_pkg;
    localparam int COORD_W_DEF  = 10;
    localparam int NUM_SEGS_DEF = 16;
    localparam int RGB_W        = 12;
    localparam logic [RGB_W-1:0] RGB_BLACK = '0;

    // One platform segment; pos is the across-axis centre line, start/len span the along axis.
    typedef struct packed {
        logic                   en;
        logic                   vert;
        logic [COORD_W_DEF-1:0] pos;
        logic [COORD_W_DEF-1:0] start;
        logic [COORD_W_DEF-1:0] len;
    } seg_t;
endpackage

// File: rtl/layer_compositor_if.sv
// Pixel stream, segment-table write port, sprite parameters and composited output.
interface layer_compositor_if
    import layer_compositor_pkg::*;
#(
    parameter int NUM_SEGS    = 16,
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10
);
    localparam int ADDR_W = $clog2(NUM_SEGS);

    logic                                vde;
    logic [COORD_W-1:0]                  DrawX;
    logic [COORD_W-1:0]                  DrawY;
    logic [3:0]                          bg_red;
    logic [3:0]                          bg_green;
    logic [3:0]                          bg_blue;
    logic                                seg_we;
    logic [ADDR_W-1:0]                   seg_addr;
    seg_t                                seg_data;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] sprite_x;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] sprite_y;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] sprite_r;
    logic [NUM_SPRITES-1:0]              sprite_wide;
    logic [NUM_SPRITES-1:0][11:0]        sprite_rgb;
    logic [11:0]                         seg_rgb;
    logic [3:0]                          Red;
    logic [3:0]                          Green;
    logic [3:0]                          Blue;
    logic                                vde_out;
    logic                                commit;

    modport master (
        output vde, DrawX, DrawY, bg_red, bg_green, bg_blue,
        output seg_we, seg_addr, seg_data,
        output sprite_x, sprite_y, sprite_r, sprite_wide, sprite_rgb, seg_rgb,
        input  Red, Green, Blue, vde_out, commit
    );

    modport slave (
        input  vde, DrawX, DrawY, bg_red, bg_green, bg_blue,
        input  seg_we, seg_addr, seg_data,
        input  sprite_x, sprite_y, sprite_r, sprite_wide, sprite_rgb, seg_rgb,
        output Red, Green, Blue, vde_out, commit
    );
endinterface

// File: rtl/layer_compositor_sprite_hit.sv
// Point-in-ellipse test for one sprite channel: dx^2+dy^2 <= r^2, or 2*dx^2+dy^2 <= r^2 when wide.
module layer_compositor_sprite_hit #(
    parameter int COORD_W = 10
) (
    input  logic signed [COORD_W:0]   i_dx,
    input  logic signed [COORD_W:0]   i_dy,
    input  logic        [COORD_W-1:0] i_r,
    input  logic                      i_wide,
    output logic                      o_hit
);
    localparam int SQ_W = 2 * COORD_W + 4;

    logic signed [SQ_W-1:0] w_dx_ext, w_dy_ext, w_r_ext;
    logic signed [SQ_W-1:0] w_dx2, w_dy2, w_r2, w_lhs;

    // Headroom: 2*dx^2 + dy^2 stays below 2^(2*COORD_W+2), so no overflow in SQ_W signed bits.
    assign w_dx_ext = SQ_W'(i_dx);
    assign w_dy_ext = SQ_W'(i_dy);
    assign w_r_ext  = SQ_W'({1'b0, i_r});
    assign w_dx2    = w_dx_ext * w_dx_ext;
    assign w_dy2    = w_dy_ext * w_dy_ext;
    assign w_r2     = w_r_ext * w_r_ext;
    assign w_lhs    = i_wide ? (w_dx2 <<< 1) + w_dy2 : w_dx2 + w_dy2;
    assign o_hit    = (w_lhs <= w_r2);
endmodule

// File: rtl/layer_compositor.sv
// Composites double-buffered platform segments and N sprites over the background stream.
// Three-stage pipeline; shadow segment bank is copied to the active bank once per frame.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int NUM_SEGS    = NUM_SEGS_DEF,
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int HALF_THICK  = 2,
    parameter int V_ACTIVE    = 480
) (
    input logic               Clk,
    input logic               Reset,
    layer_compositor_if.slave bus
);
    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] HT = CW1'(HALF_THICK);

    seg_t r_shadow [NUM_SEGS];
    seg_t r_active [NUM_SEGS];
    logic r_pending;
    logic r_commit;
    logic w_do_commit;

    logic [NUM_SPRITES-1:0][CW1-1:0]     w_dx, w_dy;
    logic                                r_vld_p1;
    logic [COORD_W-1:0]                  r_x_p1, r_y_p1;
    logic [RGB_W-1:0]                    r_bg_p1, r_segrgb_p1;
    logic [NUM_SPRITES-1:0][CW1-1:0]     r_dx_p1, r_dy_p1;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] r_r_p1;
    logic [NUM_SPRITES-1:0]              r_wide_p1;
    logic [NUM_SPRITES-1:0][RGB_W-1:0]   r_sprgb_p1;

    logic [NUM_SEGS-1:0]                 w_seg_hit;
    logic [NUM_SPRITES-1:0]              w_spr_hit;
    logic                                r_vld_p2;
    logic [NUM_SEGS-1:0]                 r_seghit_p2;
    logic [NUM_SPRITES-1:0]              r_sprhit_p2;
    logic [RGB_W-1:0]                    r_bg_p2, r_segrgb_p2;
    logic [NUM_SPRITES-1:0][RGB_W-1:0]   r_sprgb_p2;

    logic [RGB_W-1:0]                    w_rgb;
    logic                                r_vld_p3;
    logic [RGB_W-1:0]                    r_rgb_p3;

    // A write on the commit cycle lands in shadow after the copy, so it waits for next frame.
    assign w_do_commit = r_pending && (bus.DrawX == '0) && (bus.DrawY == COORD_W'(V_ACTIVE));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int s = 0; s < NUM_SEGS; s++) begin
                r_shadow[s] <= '0;
                r_active[s] <= '0;
            end
            r_pending <= 1'b0;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= w_do_commit;
            if (w_do_commit) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (bus.seg_we) begin
                r_shadow[bus.seg_addr] <= bus.seg_data;
                r_pending              <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_rgb_p3 <= RGB_BLACK;
        end else begin
            r_vld_p1 <= bus.vde;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
            r_rgb_p3 <= r_vld_p2 ? w_rgb : RGB_BLACK;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_dx[i] = {1'b0, bus.DrawX} - {1'b0, bus.sprite_x[i]};
            w_dy[i] = {1'b0, bus.DrawY} - {1'b0, bus.sprite_y[i]};
        end
    end

    // ---- Stage 1: pixel, background, sprite parameters and offsets ----
    always_ff @(posedge Clk) begin
        r_x_p1      <= bus.DrawX;
        r_y_p1      <= bus.DrawY;
        r_bg_p1     <= {bus.bg_red, bus.bg_green, bus.bg_blue};
        r_segrgb_p1 <= bus.seg_rgb;
        r_dx_p1     <= w_dx;
        r_dy_p1     <= w_dy;
        r_r_p1      <= bus.sprite_r;
        r_wide_p1   <= bus.sprite_wide;
        r_sprgb_p1  <= bus.sprite_rgb;
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
        layer_compositor_sprite_hit #(.COORD_W(COORD_W)) u_hit (
            .i_dx   (r_dx_p1[g]),
            .i_dy   (r_dy_p1[g]),
            .i_r    (r_r_p1[g]),
            .i_wide (r_wide_p1[g]),
            .o_hit  (w_spr_hit[g])
        );
    end

    // Constants are only ever added, so nothing wraps near coordinate 0 or the top of range.
    always_comb begin
        logic [CW1-1:0] w_across;
        logic [CW1-1:0] w_along;
        w_seg_hit = '0;
        w_across  = '0;
        w_along   = '0;
        for (int s = 0; s < NUM_SEGS; s++) begin
            w_across     = r_active[s].vert ? {1'b0, r_x_p1} : {1'b0, r_y_p1};
            w_along      = r_active[s].vert ? {1'b0, r_y_p1} : {1'b0, r_x_p1};
            w_seg_hit[s] = r_active[s].en
                        && (w_across + HT >= {1'b0, r_active[s].pos})
                        && (w_across <= {1'b0, r_active[s].pos} + HT)
                        && (w_along >= {1'b0, r_active[s].start})
                        && (w_along <= {1'b0, r_active[s].start} + {1'b0, r_active[s].len});
        end
    end

    // ---- Stage 2: segment and sprite hit vectors ----
    always_ff @(posedge Clk) begin
        r_seghit_p2 <= w_seg_hit;
        r_sprhit_p2 <= w_spr_hit;
        r_bg_p2     <= r_bg_p1;
        r_segrgb_p2 <= r_segrgb_p1;
        r_sprgb_p2  <= r_sprgb_p1;
    end

    // Walk sprites from highest index down so the lowest hit index is the final winner.
    always_comb begin
        w_rgb = r_bg_p2;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_sprhit_p2[i]) w_rgb = r_sprgb_p2[i];
        end
        if (|r_seghit_p2) w_rgb = r_segrgb_p2;
    end

    // ---- Stage 3: registered RGB (r_rgb_p3, r_vld_p3 above) ----
    assign bus.Red     = r_rgb_p3[11:8];
    assign bus.Green   = r_rgb_p3[7:4];
    assign bus.Blue    = r_rgb_p3[3:0];
    assign bus.vde_out = r_vld_p3;
    assign bus.commit  = r_commit;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus random traffic against a pixel-rule model.
module tb_layer_compositor;
    import layer_compositor_pkg::*;

    localparam int NS  = 16;
    localparam int NSP = 4;
    localparam int CW  = 10;
    localparam int HT  = 2;
    localparam int VA  = 480;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_compositor_if #(.NUM_SEGS(NS), .NUM_SPRITES(NSP), .COORD_W(CW)) bus ();

    layer_compositor #(
        .NUM_SEGS(NS), .NUM_SPRITES(NSP), .COORD_W(CW), .HALF_THICK(HT), .V_ACTIVE(VA)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    seg_t m_shadow [NS];
    seg_t m_active [NS];
    bit   m_pending;
    logic [12:0] exp_q [$];

    function automatic seg_t mk_seg(bit en, bit vert, int pos, int start, int len);
        seg_t s;
        s.en = en; s.vert = vert;
        s.pos = CW'(pos); s.start = CW'(start); s.len = CW'(len);
        return s;
    endfunction

    // Colour of one pixel from the drawing rules, using plain integer geometry.
    function automatic logic [11:0] model_colour(int x, int y, logic [11:0] bg);
        for (int s = 0; s < NS; s++) begin
            int across, along, pos, st, ln;
            across = m_active[s].vert ? x : y;
            along  = m_active[s].vert ? y : x;
            pos = int'(m_active[s].pos); st = int'(m_active[s].start); ln = int'(m_active[s].len);
            if (m_active[s].en && across >= pos - HT && across <= pos + HT && along >= st && along <= st + ln)
                return bus.seg_rgb;
        end
        for (int i = 0; i < NSP; i++) begin
            int dx, dy, r, d;
            dx = x - int'(bus.sprite_x[i]);
            dy = y - int'(bus.sprite_y[i]);
            r  = int'(bus.sprite_r[i]);
            d  = (bus.sprite_wide[i] ? 2 : 1) * dx * dx + dy * dy;
            if (d <= r * r) return bus.sprite_rgb[i];
        end
        return bg;
    endfunction

    task automatic reset_model();
        for (int s = 0; s < NS; s++) begin
            m_shadow[s] = '0;
            m_active[s] = '0;
        end
        m_pending = 1'b0;
        exp_q = '{13'h0, 13'h0};
    endtask

    // Advances model and DUT by one pixel; returns expected and observed {commit, vde_out, RGB}.
    task automatic tick(output logic [13:0] exp_o, output logic [13:0] obs_o);
        logic [11:0] col;
        bit cm;
        cm = (bus.DrawX == 0) && (int'(bus.DrawY) == VA) && m_pending;
        if (cm) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (bus.seg_we) begin
            m_shadow[bus.seg_addr] = bus.seg_data;
            m_pending = 1'b1;
        end
        col = bus.vde ? model_colour(int'(bus.DrawX), int'(bus.DrawY),
                                     {bus.bg_red, bus.bg_green, bus.bg_blue}) : 12'h0;
        exp_q.push_back({bus.vde, col});
        @(posedge clk);
        #1;
        exp_o = {cm, exp_q.pop_front()};
        obs_o = {bus.commit, bus.vde_out, bus.Red, bus.Green, bus.Blue};
    endtask

    task automatic set_pixel(int x, int y, bit vde);
        bus.DrawX = CW'(x);
        bus.DrawY = CW'(y);
        bus.vde   = vde;
        {bus.bg_red, bus.bg_green, bus.bg_blue} = 12'($urandom);
        bus.seg_we = 1'b0;
    endtask

    task automatic set_sprite(int i, int x, int y, int r, bit wide, logic [11:0] rgb);
        bus.sprite_x[i] = CW'(x);
        bus.sprite_y[i] = CW'(y);
        bus.sprite_r[i] = CW'(r);
        bus.sprite_wide[i] = wide;
        bus.sprite_rgb[i] = rgb;
    endtask

    task automatic write_seg(int addr, seg_t s);
        logic [13:0] e, o;
        set_pixel(1, 1, 1'b0);
        bus.seg_we = 1'b1;
        bus.seg_addr = 4'(addr);
        bus.seg_data = s;
        tick(e, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL seg_write addr=%0d: got %h, expected %h", addr, o, e);
        end
        bus.seg_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e, o;
        set_pixel(0, 0, 1'b0);
        bus.seg_addr = '0;
        bus.seg_data = '0;
        bus.seg_rgb  = 12'hF0F;
        for (int i = 0; i < NSP; i++) set_sprite(i, 1023, 1023, 0, 1'b0, 12'(12'h100 * (i + 1)));
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o = {bus.commit, bus.vde_out, bus.Red, bus.Green, bus.Blue};
        checks++;
        if (o !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0000", o);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int k = 0; k < 6; k++) begin
            set_pixel(100, 50, 1'b1);
            {bus.bg_red, bus.bg_green, bus.bg_blue} = 12'h123;
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bg_passthrough cycle %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_segment();
        logic [13:0] e, o;
        int px [7] = '{60, 60, 71, 70, 50, 49, 60};
        int py [7] = '{102, 103, 100, 100, 98, 100, 97};
        write_seg(0, mk_seg(1, 0, 100, 50, 20));
        for (int k = 0; k < 11; k++) begin
            if (k < 2) set_pixel(0, VA, 1'b0);
            else if (k < 9) set_pixel(px[k-2], py[k-2], 1'b1);
            else set_pixel(1, 1, 1'b0);
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL segment step %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [13:0] e, o;
        int px [12] = '{5, 15, 16, 5, 5, 1023, 1000, 999, 1021, 1023, 1020, 10};
        int py [12] = '{0, 0, 0, 3, 2, 300, 298, 300, 2, 5, 2, 600};
        write_seg(1, mk_seg(1, 0, 1, 5, 10));
        write_seg(2, mk_seg(1, 0, 300, 1000, 30));
        write_seg(3, mk_seg(1, 1, 1023, 0, 5));
        write_seg(4, mk_seg(0, 0, 600, 0, 1023));
        for (int k = 0; k < 15; k++) begin
            if (k == 0) set_pixel(0, VA, 1'b0);
            else if (k < 13) set_pixel(px[k-1], py[k-1], 1'b1);
            else set_pixel(1, 1, 1'b0);
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boundary step %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_sprites();
        logic [13:0] e, o;
        int px [10] = '{200, 205, 210, 211, 206, 204, 208, 200, 200, 402};
        int py [10] = '{200, 205, 200, 200, 200, 200, 200, 209, 211, 400};
        set_sprite(0, 200, 200, 10, 1'b0, 12'hA11);
        set_sprite(1, 200, 200, 10, 1'b0, 12'h1B1);
        set_sprite(2, 400, 400, 5, 1'b1, 12'h11C);
        set_sprite(3, 900, 900, 0, 1'b0, 12'hDDD);
        for (int k = 0; k < 12; k++) begin
            if (k < 10) set_pixel(px[k], py[k], 1'b1);
            else set_pixel(1, 1, 1'b0);
            bus.sprite_wide[0] = (k >= 4);
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sprite step %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_commit_race();
        logic [13:0] e, o;
        write_seg(5, mk_seg(1, 0, 700, 0, 100));
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: begin
                    set_pixel(0, VA, 1'b0);
                    bus.seg_we = 1'b1;
                    bus.seg_addr = 4'd6;
                    bus.seg_data = mk_seg(1, 1, 800, 600, 200);
                end
                1: set_pixel(50, 700, 1'b1);
                2: set_pixel(800, 700, 1'b1);
                3: set_pixel(0, VA, 1'b0);
                4: set_pixel(800, 700, 1'b1);
                5: set_pixel(801, 650, 1'b1);
                default: set_pixel(1, 1, 1'b0);
            endcase
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL commit_race step %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] e, o;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 40) == 0) set_pixel(0, VA, 1'($urandom));
            else set_pixel($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                bus.seg_we = 1'b1;
                bus.seg_addr = 4'($urandom_range(0, NS - 1));
                bus.seg_data = mk_seg(1'($urandom), 1'($urandom), $urandom_range(0, 1023),
                                      $urandom_range(0, 1023), $urandom_range(0, 300));
            end
            if ($urandom_range(0, 15) == 0) begin
                set_sprite($urandom_range(0, NSP - 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                           $urandom_range(0, 150), 1'($urandom), 12'($urandom));
            end
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random cycle %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [13:0] e, o;
        for (int i = 0; i < NSP; i++) set_sprite(i, 1023, 1023, 0, 1'b0, 12'h777);
        write_seg(7, mk_seg(1, 0, 50, 0, 1023));
        set_pixel(0, VA, 1'b0);
        tick(e, o);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL midreset_commit: got %h, expected %h", o, e);
        end
        for (int k = 0; k < 4; k++) begin
            set_pixel(10 + k, 50, 1'b1);
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset_pre step %0d: got %h, expected %h", k, o, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        o = {bus.commit, bus.vde_out, bus.Red, bus.Green, bus.Blue};
        checks++;
        if (o !== 14'h0) begin
            errors++;
            $display("FAIL midreset_black: got %h, expected 0000", o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int k = 0; k < 8; k++) begin
            if (k == 4) set_pixel(0, VA, 1'b0);
            else set_pixel(20 + k, 50, 1'b1);
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset_post step %0d: got %h, expected %h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_segment();
        test_boundaries();
        test_sprites();
        test_commit_race();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
